// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter between the I-side and D-side L1 caches.
package l2_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  function automatic arb_state_t busy_state(input arb_owner_t owner);
    return (owner == OWN_I) ? ARB_BUSY_I : ARB_BUSY_D;
  endfunction

endpackage

// File: rtl/l2_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side that was not granted last.
module l2_arb_rr_pick
  import l2_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    // NOTE: every output gets a default before the ifs so no latch is inferred.
    grant_owner = OWN_I;
    if (req_i && req_d) begin
      grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one l2_cache line port between the I-side and D-side L1 caches: round-robin grant,
// latched request held on the L2 port until l2_mem_resp, response routed back to the owner.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  input  logic              l2_mem_resp,
  output logic              arb_busy
);

  arb_state_t  state;
  arb_owner_t  last_grant;
  logic        grant_valid;
  arb_owner_t  grant_owner;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [LINE_W-1:0] sel_wdata;

  l2_arb_rr_pick u_rr_pick (
    .req_i       (i_mem_read | i_mem_write),
    .req_d       (d_mem_read | d_mem_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign sel_read    = (grant_owner == OWN_D) ? d_mem_read    : i_mem_read;
  assign sel_write   = (grant_owner == OWN_D) ? d_mem_write   : i_mem_write;
  assign sel_address = (grant_owner == OWN_D) ? d_mem_address : i_mem_address;
  assign sel_wdata   = (grant_owner == OWN_D) ? d_mem_wdata   : i_mem_wdata;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      last_grant     <= OWN_I;
      l2_mem_read    <= 1'b0;
      l2_mem_write   <= 1'b0;
      // NOTE: the wide address/data latches are reset too, so the L2 port shows zeros out of reset.
      l2_mem_address <= '0;
      l2_mem_wdata   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            // A combined read+write is issued as a write; the read is dropped.
            l2_mem_write   <= sel_write;
            l2_mem_read    <= sel_read & ~sel_write;
            l2_mem_address <= sel_address;
            l2_mem_wdata   <= sel_wdata;
            last_grant     <= grant_owner;
            state          <= busy_state(grant_owner);
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          // Always return through IDLE so a held request is never re-granted back-to-back.
          if (l2_mem_resp) begin
            l2_mem_read  <= 1'b0;
            l2_mem_write <= 1'b0;
            state        <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign i_mem_resp  = (state == ARB_BUSY_I) & l2_mem_resp;
  assign d_mem_resp  = (state == ARB_BUSY_D) & l2_mem_resp;
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;
  assign arb_busy    = (state != ARB_IDLE);

endmodule
